// File: rtl/bcd_sseg_loader.sv
// Expands one signed BCD word into a most-significant-first burst of single-digit
// writes for sseg_array, with leading-zero blanking, sign placement and decimal points.
module bcd_sseg_loader #(
  parameter int BCD_N     = 4,
  parameter int SSEG_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*BCD_N-1:0]     bcd,
  input  logic                   sign,
  input  logic [SSEG_BITS-1:0]   base,
  input  logic [BCD_N-1:0]       dp_mask,
  input  logic                   blank_lz,
  output logic                   ready,
  output logic                   wr,
  output logic [SSEG_BITS-1:0]   sel,
  output logic                   en,
  output logic                   sign_o,
  output logic                   dp,
  output logic [3:0]             val,
  output logic                   done_tick
);

  localparam int KW = (BCD_N > 1) ? $clog2(BCD_N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_e;

  // Zero digits counted from the top; the loop stops at digit 1 so digit 0 always shows.
  function automatic logic [KW-1:0] calc_lz(input logic [4*BCD_N-1:0] w, input logic blank);
    logic [KW-1:0] cnt;
    logic          run;
    cnt = '0;
    run = blank;
    for (int i = BCD_N - 1; i >= 1; i--) begin
      if (run && (w[4*i +: 4] == 4'd0)) cnt = cnt + KW'(1);
      else                              run = 1'b0;
    end
    return cnt;
  endfunction

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   wr_q, wr_d, en_q, en_d, sgn_q, sgn_d, dp_q, dp_d, done_q, done_d;
  logic [SSEG_BITS-1:0]   sel_q, sel_d;
  logic [3:0]             val_q, val_d;

  logic [4*BCD_N-1:0]     bcd_q, src_bcd;
  logic                   neg_q, src_neg;
  logic [SSEG_BITS-1:0]   base_q, src_base;
  logic [BCD_N-1:0]       dpm_q, src_dpm;
  logic [KW-1:0]          lz_q, lz_in, src_lz;
  logic                   load, emit;
  int                     first_lit, kk;

  assign lz_in = calc_lz(bcd, blank_lz);

  // The first digit is computed straight from the ports so its write lands in cycle 1.
  assign src_bcd  = (state_q == S_IDLE) ? bcd     : bcd_q;
  assign src_neg  = (state_q == S_IDLE) ? sign    : neg_q;
  assign src_base = (state_q == S_IDLE) ? base    : base_q;
  assign src_dpm  = (state_q == S_IDLE) ? dp_mask : dpm_q;
  assign src_lz   = (state_q == S_IDLE) ? lz_in   : lz_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    sel_d     = sel_q;
    en_d      = en_q;
    sgn_d     = sgn_q;
    dp_d      = dp_q;
    val_d     = val_q;
    load      = 1'b0;
    emit      = 1'b0;
    first_lit = 0;
    kk        = 0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          k_d     = KW'(BCD_N - 1);
          load    = 1'b1;
          emit    = 1'b1;
        end
      end
      S_WRITE: begin
        // The gap after digit 0 is replaced by DONE to keep done_tick at cycle 2*BCD_N.
        if (k_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_WRITE;
        k_d     = k_q - KW'(1);
        emit    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      first_lit = BCD_N - int'(src_lz);
      kk        = int'(k_d);
      wr_d      = 1'b1;
      sel_d     = src_base + SSEG_BITS'(k_d);
      if (src_neg && (src_lz != '0) && (kk == first_lit)) begin
        en_d  = 1'b1;
        sgn_d = 1'b1;
        val_d = 4'd0;
        dp_d  = 1'b0;
      end else if (kk >= first_lit) begin
        en_d  = 1'b0;
        sgn_d = 1'b0;
        val_d = 4'd0;
        dp_d  = 1'b0;
      end else begin
        en_d  = 1'b1;
        val_d = src_bcd[4*k_d +: 4];
        dp_d  = src_dpm[k_d];
        sgn_d = src_neg && (src_lz == '0) && (kk == BCD_N - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      sgn_q   <= 1'b0;
      dp_q    <= 1'b0;
      val_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      sgn_q   <= sgn_d;
      dp_q    <= dp_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      bcd_q  <= bcd;
      neg_q  <= sign;
      base_q <= base;
      dpm_q  <= dp_mask;
      lz_q   <= lz_in;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign wr        = wr_q;
  assign sel       = sel_q;
  assign en        = en_q;
  assign sign_o    = sgn_q;
  assign dp        = dp_q;
  assign val       = val_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_bcd_sseg_loader.sv
// Scoreboard bench for bcd_sseg_loader: directed bursts push hand-computed writes,
// a negedge monitor pops and compares each write strobe and done pulse.
module tb_bcd_sseg_loader;

  logic        clk = 1'b0;
  logic        reset, start, sign, blank_lz;
  logic [15:0] bcd;
  logic [4:0]  base;
  logic [3:0]  dp_mask;
  logic        ready, wr, en, sign_o, dp, done_tick;
  logic [4:0]  sel;
  logic [3:0]  val;

  bcd_sseg_loader #(.BCD_N(4), .SSEG_BITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .bcd(bcd), .sign(sign), .base(base),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .ready(ready), .wr(wr), .sel(sel), .en(en),
    .sign_o(sign_o), .dp(dp), .val(val), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] sel;
    logic       en;
    logic       sg;
    logic       dp;
    logic [3:0] val;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  t0 = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic ew(input int rel, input logic [4:0] s, input logic e, input logic g,
                    input logic d, input logic [3:0] v);
    wr_t x;
    x.cyc = t0 + rel; x.sel = s; x.en = e; x.sg = g; x.dp = d; x.val = v;
    wq.push_back(x);
  endtask

  task automatic ed(input int rel);
    dq.push_back(t0 + rel);
  endtask

  // Monitor: every strobe must match the head of its queue, in the expected cycle.
  always @(negedge clk) begin
    if (wr) begin
      if (wq.size() == 0) begin
        chk("unexpected_wr", {27'd0, sel}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_sel", {27'd0, sel}, {27'd0, e.sel});
        chk("wr_en_sign_dp_val", {25'd0, en, sign_o, dp, val}, {25'd0, e.en, e.sg, e.dp, e.val});
      end
    end
    if (done_tick) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else                chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic launch(input logic [15:0] b, input logic s, input logic [4:0] ba,
                        input logic [3:0] dm, input logic bl);
    @(posedge clk); #1;
    bcd = b; sign = s; base = ba; dp_mask = dm; blank_lz = bl; start = 1'b1;
    t0 = cyc;
    chk("ready_at_start", ready, 1'b1);
  endtask

  // Scramble the inputs after the start cycle to prove the word was latched.
  task automatic settle();
    @(posedge clk); #1;
    start = 1'b0; bcd = 16'hFFFF; base = 5'h0A; sign = ~sign; dp_mask = 4'hF; blank_lz = ~blank_lz;
    repeat (10) @(posedge clk);
    #1;
    chk("wr_pending", wq.size(), 0);
    chk("done_pending", dq.size(), 0);
    chk("ready_after", ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sign = 1'b0; blank_lz = 1'b0;
    bcd = '0; base = '0; dp_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_outputs", {wr, sel, en, sign_o, dp, val, done_tick}, '0);
    reset = 1'b0;

    // leading zeros blanked
    launch(16'h0042, 1'b0, 5'd0, 4'b0000, 1'b1);
    ew(1, 5'd3, 0, 0, 0, 4'd0); ew(3, 5'd2, 0, 0, 0, 4'd0);
    ew(5, 5'd1, 1, 0, 0, 4'd4); ew(7, 5'd0, 1, 0, 0, 4'd2); ed(8);
    settle();

    // minus sign sits just left of the first significant digit
    launch(16'h0042, 1'b1, 5'd0, 4'b0000, 1'b1);
    ew(1, 5'd3, 0, 0, 0, 4'd0); ew(3, 5'd2, 1, 1, 0, 4'd0);
    ew(5, 5'd1, 1, 0, 0, 4'd4); ew(7, 5'd0, 1, 0, 0, 4'd2); ed(8);
    settle();

    // no leading zeros: sign rides on the top digit, address wraps
    launch(16'h1234, 1'b1, 5'd30, 4'b0000, 1'b1);
    ew(1, 5'd1, 1, 1, 0, 4'd1); ew(3, 5'd0, 1, 0, 0, 4'd2);
    ew(5, 5'd31, 1, 0, 0, 4'd3); ew(7, 5'd30, 1, 0, 0, 4'd4); ed(8);
    settle();

    // zero value keeps digit 0 visible
    launch(16'h0000, 1'b0, 5'd0, 4'b0000, 1'b1);
    ew(1, 5'd3, 0, 0, 0, 4'd0); ew(3, 5'd2, 0, 0, 0, 4'd0);
    ew(5, 5'd1, 0, 0, 0, 4'd0); ew(7, 5'd0, 1, 0, 0, 4'd0); ed(8);
    settle();

    launch(16'h0000, 1'b0, 5'd0, 4'b0000, 1'b0);
    ew(1, 5'd3, 1, 0, 0, 4'd0); ew(3, 5'd2, 1, 0, 0, 4'd0);
    ew(5, 5'd1, 1, 0, 0, 4'd0); ew(7, 5'd0, 1, 0, 0, 4'd0); ed(8);
    settle();

    // decimal point on digit 1 only
    launch(16'h5678, 1'b0, 5'd0, 4'b0010, 1'b0);
    ew(1, 5'd3, 1, 0, 0, 4'd5); ew(3, 5'd2, 1, 0, 0, 4'd6);
    ew(5, 5'd1, 1, 0, 1, 4'd7); ew(7, 5'd0, 1, 0, 0, 4'd8); ed(8);
    settle();

    // non-decimal digit counts as non-zero; sign digit never gets a dp
    launch(16'h0A05, 1'b1, 5'd4, 4'b1111, 1'b1);
    ew(1, 5'd7, 1, 1, 0, 4'd0); ew(3, 5'd6, 1, 0, 1, 4'hA);
    ew(5, 5'd5, 1, 0, 1, 4'd0); ew(7, 5'd4, 1, 0, 1, 4'd5); ed(8);
    settle();

    // start during a burst is ignored
    launch(16'h0042, 1'b0, 5'd0, 4'b0000, 1'b1);
    ew(1, 5'd3, 0, 0, 0, 4'd0); ew(3, 5'd2, 0, 0, 0, 4'd0);
    ew(5, 5'd1, 1, 0, 0, 4'd4); ew(7, 5'd0, 1, 0, 0, 4'd2); ed(8);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; bcd = 16'h9999; base = 5'd9;
    chk("ready_busy", ready, 1'b0);
    settle();

    // reset in cycle 3 aborts the burst
    launch(16'h1234, 1'b0, 5'd0, 4'b0000, 1'b0);
    ew(1, 5'd3, 1, 0, 0, 4'd1); ew(3, 5'd2, 1, 0, 0, 4'd2);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_outputs", {wr, sel, en, sign_o, dp, val, done_tick}, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_wr_pending", wq.size(), 0);

    // normal run after the abort
    launch(16'h5678, 1'b0, 5'd0, 4'b0000, 1'b0);
    ew(1, 5'd3, 1, 0, 0, 4'd5); ew(3, 5'd2, 1, 0, 0, 4'd6);
    ew(5, 5'd1, 1, 0, 0, 4'd7); ew(7, 5'd0, 1, 0, 0, 4'd8); ed(8);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
